// File: rtl/nn_upscale_engine.sv
`timescale 1ns/1ps
// Nearest-neighbour zoom engine: walks the destination frame in raster order, one ROM read and one RAM write per pixel.
// Latency: first R_ADDR one clock after START, first WREN ROM_LATENCY clocks later, DONE one clock after the last write.
// Backpressure: none; the engine streams at one pixel per clock and ignores START until it is back in IDLE.
// Optional feature: define NN_UPSCALE_CHECKSUM_EN to add the 16-bit CHECKSUM output (sum of written pixels per frame).
module nn_upscale_engine #(
    parameter int SRC_W       = 160,
    parameter int SRC_H       = 120,
    parameter int SCALE       = 2,
    parameter int ROM_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [14:0] R_ADDR,
    input  logic [7:0]  PIXEL_IN,
    output logic [16:0] W_ADDR,
    output logic [7:0]  PIXEL_OUT,
    output logic        WREN,
    output logic        BUSY,
    output logic        DONE
`ifdef NN_UPSCALE_CHECKSUM_EN
    ,
    output logic [15:0] CHECKSUM
`endif
);

    function automatic int bits_for(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int DST_W   = SRC_W * SCALE;
    localparam int DST_H   = SRC_H * SCALE;
    localparam int NPIX    = DST_W * DST_H;
    localparam int SRC_PIX = SRC_W * SRC_H;
    localparam int KW      = bits_for(SCALE);
    localparam int SXW     = bits_for(SRC_W);
    localparam int DXW     = bits_for(DST_W);
    localparam int DYW     = bits_for(DST_H);
    localparam int RBW     = bits_for(SRC_PIX);
    localparam int NW      = bits_for(NPIX);

    // Parameter sanity: the frame must fit the RAM address port, the source the ROM port.
    if (NPIX > (1 << 17)) begin : g_dst_too_big
        $error("nn_upscale_engine: DST_W*DST_H exceeds the 17-bit W_ADDR range");
    end
    if (SRC_PIX > (1 << 15)) begin : g_src_too_big
        $error("nn_upscale_engine: SRC_W*SRC_H exceeds the 15-bit R_ADDR range");
    end
    if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
        $error("nn_upscale_engine: SCALE must be 1..4");
    end
    if (ROM_LATENCY < 1 || ROM_LATENCY > 3) begin : g_bad_latency
        $error("nn_upscale_engine: ROM_LATENCY must be 1..3");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t           state, state_nxt;

    // Destination walk: dx/dy are the raster position, kx/ky count replicas of one source pixel.
    logic [DXW-1:0]   dx;
    logic [DYW-1:0]   dy;
    logic [KW-1:0]    kx, ky;
    logic [SXW-1:0]   sx;
    logic [RBW-1:0]   row_base;
    logic [NW-1:0]    wr_cnt;

    // Read-return tracking: index 0 is the newest read, ROM_LATENCY-1 lines up with PIXEL_IN.
    logic [ROM_LATENCY-1:0] vld;
    logic [NW-1:0]          adr_pipe [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] ahead;

    logic issue, row_end, last_pix, kx_wrap, ky_wrap, pipe_clear;

    assign issue      = (state == ISSUE);
    assign row_end    = (dx == DXW'(DST_W - 1));
    assign last_pix   = row_end && (dy == DYW'(DST_H - 1));
    assign kx_wrap    = (kx == KW'(SCALE - 1));
    assign ky_wrap    = (ky == KW'(SCALE - 1));
    // Only the tail stage may still be busy when the last write is on the bus.
    assign ahead      = vld << 1;
    assign pipe_clear = (ahead == '0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: IDLE -> ISSUE on START, ISSUE -> DRAIN after the last read, DRAIN -> FIN once returns are in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = ISSUE;
            ISSUE:   if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (pipe_clear) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinate counters: advance once per issued read and fall back to zero after the last pixel.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dx       <= '0;
            dy       <= '0;
            kx       <= '0;
            ky       <= '0;
            sx       <= '0;
            row_base <= '0;
            wr_cnt   <= '0;
        end else if (issue) begin
            wr_cnt <= last_pix ? '0 : wr_cnt + NW'(1);
            if (row_end) begin
                dx <= '0;
                kx <= '0;
                sx <= '0;
                if (last_pix) begin
                    dy       <= '0;
                    ky       <= '0;
                    row_base <= '0;
                end else begin
                    dy <= dy + DYW'(1);
                    if (ky_wrap) begin
                        ky       <= '0;
                        row_base <= row_base + RBW'(SRC_W);
                    end else begin
                        ky <= ky + KW'(1);
                    end
                end
            end else begin
                dx <= dx + DXW'(1);
                if (kx_wrap) begin
                    kx <= '0;
                    sx <= sx + SXW'(1);
                end else begin
                    kx <= kx + KW'(1);
                end
            end
        end
    end

    // Valid/address shift register matching the ROM read latency.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) adr_pipe[i] <= '0;
        end else begin
            vld[0]      <= issue;
            adr_pipe[0] <= issue ? wr_cnt : '0;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld[i]      <= vld[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    // ROM data passes straight through so the write strobe, address and data share one cycle.
    assign R_ADDR    = 15'(row_base) + 15'(sx);
    assign WREN      = vld[ROM_LATENCY-1];
    assign W_ADDR    = 17'(adr_pipe[ROM_LATENCY-1]);
    assign PIXEL_OUT = WREN ? PIXEL_IN : 8'h00;
    assign BUSY      = (state == ISSUE) || (state == DRAIN);
    assign DONE      = (state == FIN);

`ifdef NN_UPSCALE_CHECKSUM_EN
    // Frame checksum: cleared on an accepted START, accumulates every written pixel, holds after DONE.
    always_ff @(posedge CLK) begin
        if (RESET)                       CHECKSUM <= '0;
        else if (state == IDLE && START) CHECKSUM <= '0;
        else if (WREN)                   CHECKSUM <= CHECKSUM + 16'(PIXEL_OUT);
    end
`endif

endmodule
